// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_if
// Purpose  : Bundles the two requester ports and the memory port of the
//            data-memory arbiter. The slave modport is the arbiter's view;
//            the master modport is the requester/memory side.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  // Port 0: core load/store unit
  logic              p0_req;
  logic              p0_we;
  logic              p0_ls;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_gnt;
  logic              p0_done;
  logic              p0_err;
  logic [DATA_W-1:0] p0_rdata;
  // Port 1: debug/program-loader
  logic              p1_req;
  logic              p1_we;
  logic              p1_ls;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt;
  logic              p1_done;
  logic              p1_err;
  logic [DATA_W-1:0] p1_rdata;
  // Memory side
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              mem_re;
  logic              mem_ls;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  p0_req, p0_we, p0_ls, p0_addr, p0_wdata,
    output p0_gnt, p0_done, p0_err, p0_rdata,
    input  p1_req, p1_we, p1_ls, p1_addr, p1_wdata,
    output p1_gnt, p1_done, p1_err, p1_rdata,
    output mem_addr, mem_we, mem_re, mem_ls, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output p0_req, p0_we, p0_ls, p0_addr, p0_wdata,
    input  p0_gnt, p0_done, p0_err, p0_rdata,
    output p1_req, p1_we, p1_ls, p1_addr, p1_wdata,
    input  p1_gnt, p1_done, p1_err, p1_rdata,
    input  mem_addr, mem_we, mem_re, mem_ls, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Round-robin arbiter and access sequencer sharing one data-memory
//            port between two requesters. Valid accesses take 3 cycles
//            (grant, strobe, done); misaligned word accesses take 2 cycles
//            and never touch memory.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    ERR    = 2'd3
  } state_t;

  state_t            state_q;
  logic              last_q;     // port served by the most recent grant
  logic              win_q;      // port owning the transaction in flight
  logic [1:0]        done_q;
  logic [1:0]        err_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q;
  logic              mem_re_q;
  logic              mem_ls_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic              any_req;
  logic              winner;
  logic              sel_we;
  logic              sel_ls;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              misaligned;
  logic [DATA_W-1:0] load_val;

  // Winner selection and field steering for the grant cycle
  always_comb begin
    any_req    = bus.p0_req | bus.p1_req;
    // On a tie the port not served last wins; otherwise the lone requester
    winner     = (bus.p0_req && bus.p1_req) ? ~last_q : bus.p1_req;
    sel_we     = winner ? bus.p1_we    : bus.p0_we;
    sel_ls     = winner ? bus.p1_ls    : bus.p0_ls;
    sel_addr   = winner ? bus.p1_addr  : bus.p0_addr;
    sel_wdata  = winner ? bus.p1_wdata : bus.p0_wdata;
    misaligned = sel_ls && (sel_addr[1:0] != 2'b00);
    // Byte loads keep the low lane only, zero-extended
    load_val   = mem_ls_q ? bus.mem_rdata
                          : {{(DATA_W-8){1'b0}}, bus.mem_rdata[7:0]};
  end

  assign bus.p0_gnt    = (state_q == IDLE) && any_req && !winner;
  assign bus.p1_gnt    = (state_q == IDLE) && any_req &&  winner;
  assign bus.p0_done   = done_q[0];
  assign bus.p1_done   = done_q[1];
  assign bus.p0_err    = err_q[0];
  assign bus.p1_err    = err_q[1];
  assign bus.p0_rdata  = rdata0_q;
  assign bus.p1_rdata  = rdata1_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_ls    = mem_ls_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = (state_q != IDLE);

  // Sequencer FSM with registered strobes, completion pulses and load data
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      win_q       <= 1'b0;
      done_q      <= 2'b00;
      err_q       <= 2'b00;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_ls_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      // Strobes and pulses last one cycle unless re-armed below
      mem_we_q <= 1'b0;
      mem_re_q <= 1'b0;
      done_q   <= 2'b00;
      err_q    <= 2'b00;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            win_q  <= winner;
            last_q <= winner;
            if (misaligned) begin
              // Reject without touching the memory-side registers
              state_q        <= ERR;
              done_q[winner] <= 1'b1;
              err_q[winner]  <= 1'b1;
            end else begin
              state_q     <= ACCESS;
              mem_addr_q  <= sel_addr;
              mem_ls_q    <= sel_ls;
              mem_wdata_q <= sel_wdata;
              mem_we_q    <= sel_we;
              mem_re_q    <= !sel_we;
            end
          end
        end
        ACCESS: begin
          if (mem_re_q) begin
            if (win_q) rdata1_q <= load_val;
            else       rdata0_q <= load_val;
          end
          done_q[win_q] <= 1'b1;
          state_q       <= RESP;
        end
        RESP:    state_q <= IDLE;
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Directed self-checking bench for dmem_arbiter with a byte-wide
//            little-endian memory model on the memory port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   total   = 0;
  int   bad     = 0;

  dmem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus();

  dmem_arbiter #(.ADDR_W(12), .DATA_W(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Memory model: 4 KiB of bytes, written on the rising edge of a strobe cycle
  logic [7:0] mem_bytes [0:4095];
  initial begin
    for (int i = 0; i < 4096; i++) mem_bytes[i] = 8'h00;
    forever begin
      @(posedge clk);
      if (bus.mem_we) begin
        if (bus.mem_ls) begin
          mem_bytes[{bus.mem_addr[11:2], 2'd0}] <= bus.mem_wdata[7:0];
          mem_bytes[{bus.mem_addr[11:2], 2'd1}] <= bus.mem_wdata[15:8];
          mem_bytes[{bus.mem_addr[11:2], 2'd2}] <= bus.mem_wdata[23:16];
          mem_bytes[{bus.mem_addr[11:2], 2'd3}] <= bus.mem_wdata[31:24];
        end else begin
          mem_bytes[bus.mem_addr] <= bus.mem_wdata[7:0];
        end
      end
    end
  end

  // Read data presented combinationally from the current memory address
  always_comb begin
    bus.mem_rdata = 32'h0;
    if (bus.mem_ls)
      bus.mem_rdata = {mem_bytes[{bus.mem_addr[11:2], 2'd3}], mem_bytes[{bus.mem_addr[11:2], 2'd2}],
                       mem_bytes[{bus.mem_addr[11:2], 2'd1}], mem_bytes[{bus.mem_addr[11:2], 2'd0}]};
    else
      bus.mem_rdata = {24'h0, mem_bytes[bus.mem_addr]};
  end

  typedef struct packed {
    logic        ok;
    logic        other;
    logic        we1;
    logic        re1;
    logic        ls1;
    logic [11:0] addr1;
    logic [31:0] wdata1;
    logic        done1;
    logic        err1;
    logic [31:0] rdata1;
    logic        done2;
    logic        err2;
    logic        we2;
    logic        re2;
    logic [31:0] rdata2;
  } txn_t;

  task automatic present(input int port, input logic we, input logic ls,
                         input logic [11:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      bus.p0_we = we; bus.p0_ls = ls; bus.p0_addr = addr; bus.p0_wdata = wdata; bus.p0_req = 1'b1;
    end else begin
      bus.p1_we = we; bus.p1_ls = ls; bus.p1_addr = addr; bus.p1_wdata = wdata; bus.p1_req = 1'b1;
    end
  endtask

  task automatic drop(input int port);
    if (port == 0) bus.p0_req = 1'b0;
    else           bus.p1_req = 1'b0;
  endtask

  // Runs one transaction from an IDLE negedge and records what the DUT did
  // in the cycle after the grant and the cycle after that.
  task automatic run_txn(input int port, input logic we, input logic ls,
                         input logic [11:0] addr, input logic [31:0] wdata,
                         output txn_t r);
    r = '0;
    present(port, we, ls, addr, wdata);
    #1;
    for (int i = 0; i < 20; i++) begin
      if ((port == 0) ? bus.p0_gnt : bus.p1_gnt) begin
        r.ok = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    r.other = (port == 0) ? bus.p1_gnt : bus.p0_gnt;
    @(negedge clk);
    drop(port);
    #1;
    r.we1    = bus.mem_we;
    r.re1    = bus.mem_re;
    r.ls1    = bus.mem_ls;
    r.addr1  = bus.mem_addr;
    r.wdata1 = bus.mem_wdata;
    r.done1  = (port == 0) ? bus.p0_done  : bus.p1_done;
    r.err1   = (port == 0) ? bus.p0_err   : bus.p1_err;
    r.rdata1 = (port == 0) ? bus.p0_rdata : bus.p1_rdata;
    @(negedge clk); #1;
    r.done2  = (port == 0) ? bus.p0_done  : bus.p1_done;
    r.err2   = (port == 0) ? bus.p0_err   : bus.p1_err;
    r.we2    = bus.mem_we;
    r.re2    = bus.mem_re;
    r.rdata2 = (port == 0) ? bus.p0_rdata : bus.p1_rdata;
    if (!r.done1) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_ls = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
    bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_ls = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    total++; if ({bus.p0_done, bus.p1_done, bus.p0_err, bus.p1_err} !== 4'b0000) begin
      bad++; $display("FAIL rst_done_err: got %b want 0000", {bus.p0_done, bus.p1_done, bus.p0_err, bus.p1_err});
    end
    total++; if ({bus.mem_we, bus.mem_re, bus.mem_ls} !== 3'b000) begin
      bad++; $display("FAIL rst_mem_ctl: got %b want 000", {bus.mem_we, bus.mem_re, bus.mem_ls});
    end
    total++; if ({bus.mem_addr, bus.mem_wdata} !== 44'h0) begin
      bad++; $display("FAIL rst_mem_bus: got %h/%h want 0/0", bus.mem_addr, bus.mem_wdata);
    end
    total++; if ({bus.p0_rdata, bus.p1_rdata} !== 64'h0) begin
      bad++; $display("FAIL rst_rdata: got %h/%h want 0/0", bus.p0_rdata, bus.p1_rdata);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word_store_load();
    txn_t r;
    run_txn(0, 1'b1, 1'b1, 12'h010, 32'hDEADBEEF, r);
    total++; if (r.ok !== 1'b1) begin bad++; $display("FAIL sw_gnt: got %b want 1", r.ok); end
    total++; if (r.other !== 1'b0) begin bad++; $display("FAIL sw_other_gnt: got %b want 0", r.other); end
    total++; if ({r.we1, r.re1} !== 2'b10) begin bad++; $display("FAIL sw_strobe: got %b want 10", {r.we1, r.re1}); end
    total++; if (r.addr1 !== 12'h010) begin bad++; $display("FAIL sw_addr: got %h want 010", r.addr1); end
    total++; if (r.wdata1 !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_wdata: got %h want deadbeef", r.wdata1); end
    total++; if ({r.done1, r.done2, r.err2} !== 3'b010) begin
      bad++; $display("FAIL sw_done: got %b want 010", {r.done1, r.done2, r.err2});
    end
    run_txn(0, 1'b0, 1'b1, 12'h010, 32'h0, r);
    total++; if ({r.we1, r.re1} !== 2'b01) begin bad++; $display("FAIL lw_strobe: got %b want 01", {r.we1, r.re1}); end
    total++; if ({r.done2, r.err2} !== 2'b10) begin bad++; $display("FAIL lw_done: got %b want 10", {r.done2, r.err2}); end
    total++; if (r.rdata2 !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_rdata: got %h want deadbeef", r.rdata2); end
  endtask

  task automatic test_byte_access();
    txn_t r;
    run_txn(1, 1'b1, 1'b0, 12'h013, 32'h123456A5, r);
    total++; if ({r.ok, r.we1, r.ls1} !== 3'b110) begin
      bad++; $display("FAIL sb_ctl: got %b want 110", {r.ok, r.we1, r.ls1});
    end
    total++; if (r.addr1 !== 12'h013) begin bad++; $display("FAIL sb_addr: got %h want 013", r.addr1); end
    run_txn(1, 1'b0, 1'b0, 12'h013, 32'h0, r);
    total++; if (r.rdata2 !== 32'h000000A5) begin bad++; $display("FAIL lb_rdata: got %h want 000000a5", r.rdata2); end
    run_txn(0, 1'b0, 1'b1, 12'h010, 32'h0, r);
    total++; if (r.rdata2 !== 32'hA5ADBEEF) begin bad++; $display("FAIL lw_merged: got %h want a5adbeef", r.rdata2); end
  endtask

  task automatic test_misaligned();
    txn_t r;
    run_txn(0, 1'b0, 1'b1, 12'h006, 32'h0, r);
    total++; if ({r.done1, r.err1} !== 2'b11) begin bad++; $display("FAIL mis_done_err: got %b want 11", {r.done1, r.err1}); end
    total++; if ({r.we1, r.re1, r.we2, r.re2} !== 4'b0000) begin
      bad++; $display("FAIL mis_strobes: got %b want 0000", {r.we1, r.re1, r.we2, r.re2});
    end
    total++; if (r.done2 !== 1'b0) begin bad++; $display("FAIL mis_single_done: got %b want 0", r.done2); end
    total++; if (r.rdata1 !== 32'hA5ADBEEF) begin bad++; $display("FAIL mis_rdata_held: got %h want a5adbeef", r.rdata1); end
  endtask

  task automatic test_round_robin();
    int exp_cyc [4];
    int exp_port [4];
    int k;
    exp_cyc  = '{0, 3, 6, 9};
    exp_port = '{0, 1, 0, 1};
    k = 0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    present(0, 1'b0, 1'b1, 12'h010, 32'h0);
    present(1, 1'b0, 1'b1, 12'h020, 32'h0);
    for (int c = 0; c < 12; c++) begin
      #1;
      total++; if (bus.p0_gnt && bus.p1_gnt) begin bad++; $display("FAIL rr_both_gnt: got 11 want not both at cycle %0d", c); end
      if (bus.p0_gnt || bus.p1_gnt) begin
        if (k < 4) begin
          total++; if (c != exp_cyc[k] || int'(bus.p1_gnt) != exp_port[k]) begin
            bad++; $display("FAIL rr_order: grant %0d got port %0d cycle %0d want port %0d cycle %0d",
                            k, int'(bus.p1_gnt), c, exp_port[k], exp_cyc[k]);
          end
        end
        k++;
      end
      @(negedge clk);
    end
    drop(0);
    drop(1);
    total++; if (k != 4) begin bad++; $display("FAIL rr_count: got %0d want 4", k); end
  endtask

  task automatic test_reset_mid_access();
    txn_t r;
    present(1, 1'b1, 1'b1, 12'h020, 32'hCAFEF00D);
    #1;
    total++; if (bus.p1_gnt !== 1'b1) begin bad++; $display("FAIL ra_gnt: got %b want 1", bus.p1_gnt); end
    @(negedge clk);
    drop(1);
    reset_n = 1'b0;
    @(negedge clk); #1;
    total++; if ({bus.p1_done, bus.busy} !== 2'b00) begin
      bad++; $display("FAIL ra_no_done: got %b want 00", {bus.p1_done, bus.busy});
    end
    total++; if ({bus.mem_we, bus.mem_re, bus.mem_ls, bus.mem_addr, bus.mem_wdata} !== 47'h0) begin
      bad++; $display("FAIL ra_mem_cleared: got addr %h wdata %h ctl %b want all 0",
                      bus.mem_addr, bus.mem_wdata, {bus.mem_we, bus.mem_re, bus.mem_ls});
    end
    total++; if ({bus.p0_rdata, bus.p1_rdata} !== 64'h0) begin
      bad++; $display("FAIL ra_rdata_cleared: got %h/%h want 0/0", bus.p0_rdata, bus.p1_rdata);
    end
    reset_n = 1'b1;
    @(negedge clk);
    run_txn(1, 1'b0, 1'b1, 12'h020, 32'h0, r);
    total++; if (r.rdata2 !== 32'h0 && r.rdata2 !== 32'hCAFEF00D) begin
      bad++; $display("FAIL ra_reload: got %h want 00000000 or cafef00d", r.rdata2);
    end
  endtask

  task automatic test_wait_busy();
    present(1, 1'b1, 1'b1, 12'h030, 32'h0BADCAFE);
    #1;
    total++; if (bus.p1_gnt !== 1'b1) begin bad++; $display("FAIL wb_p1_gnt: got %b want 1", bus.p1_gnt); end
    @(negedge clk);
    drop(1);
    present(0, 1'b0, 1'b1, 12'h030, 32'h0);
    #1;
    total++; if (bus.p0_gnt !== 1'b0) begin bad++; $display("FAIL wb_gnt_access: got %b want 0", bus.p0_gnt); end
    @(negedge clk); #1;
    total++; if ({bus.p0_gnt, bus.p1_done} !== 2'b01) begin
      bad++; $display("FAIL wb_gnt_resp: got %b want 01", {bus.p0_gnt, bus.p1_done});
    end
    @(negedge clk); #1;
    total++; if (bus.p0_gnt !== 1'b1) begin bad++; $display("FAIL wb_gnt_idle: got %b want 1", bus.p0_gnt); end
    @(negedge clk);
    drop(0);
    #1;
    total++; if ({bus.mem_re, bus.mem_addr} !== {1'b1, 12'h030}) begin
      bad++; $display("FAIL wb_strobe: got %b/%h want 1/030", bus.mem_re, bus.mem_addr);
    end
    @(negedge clk); #1;
    total++; if ({bus.p0_done, bus.p0_rdata} !== {1'b1, 32'h0BADCAFE}) begin
      bad++; $display("FAIL wb_load: got %b/%h want 1/0badcafe", bus.p0_done, bus.p0_rdata);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_byte_access();
    test_misaligned();
    test_round_robin();
    test_reset_mid_access();
    test_wait_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
